// File: rtl/route_pkg.sv
// rtl/route_pkg.sv - route-code limits, FSM state type and next-route helper for route_sel_ctrl
package route_pkg;
   localparam int SEL_W      = 4;
   localparam int SEL_MAX    = 11;
   localparam int PAIR_COUNT = 6;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_BLANK  = 2'd1,
      ST_COMMIT = 2'd2
   } route_state_t;

   // bits[3:1] = pair/console index, bit0 = player swap
   function automatic logic [SEL_W-1:0] next_route(input logic [SEL_W-1:0] base,
                                                   input logic             mode,
                                                   input logic             swap);
      logic [2:0] idx;
      idx = base[3:1];
      if (mode) idx = (idx == 3'(PAIR_COUNT - 1)) ? 3'd0 : idx + 3'd1;
      return {idx, base[0] ^ swap};
   endfunction
endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - 2-flop synchronizer, stable-sample debounce and single-cycle press pulse
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 250000
) (
   input  logic clk_in,
   input  logic reset_in,
   input  logic btn_in,
   output logic press_out
);
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

   logic [1:0]       r_sync;
   logic             r_level;
   logic [CNT_W-1:0] r_cnt;
   logic             r_press;

   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         r_sync  <= 2'b00;
         r_level <= 1'b0;
         r_cnt   <= '0;
         r_press <= 1'b0;
      end else begin
         r_sync  <= {r_sync[0], btn_in};
         r_press <= 1'b0;
         // any sample equal to the accepted level restarts the stability count
         if (r_sync[1] == r_level) begin
            r_cnt <= '0;
         end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            r_level <= r_sync[1];
            r_cnt   <= '0;
            r_press <= r_sync[1];
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   assign press_out = r_press;
endmodule

// File: rtl/route_sel_ctrl.sv
// rtl/route_sel_ctrl.sv - router select controller; ROUTE_BLANK_EN enables the blank/commit FSM
module route_sel_ctrl
   import route_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int BLANK_CYCLES    = 16
) (
   input  logic             clk_in,
   input  logic             reset_in,
   input  logic             mode_btn_in,
   input  logic             swap_btn_in,
   input  logic [SEL_W-1:0] host_sel_in,
   input  logic             host_load_in,
   output logic             host_ack_out,
   output logic             host_err_out,
   output logic [SEL_W-1:0] select_out,
   output logic             blank_out,
   output logic             busy_out
);
   if (BLANK_CYCLES < 1 || BLANK_CYCLES > 255) begin : g_blank_range
      $error("BLANK_CYCLES must be within 1..255");
   end

   logic             w_mode_press;
   logic             w_swap_press;
   logic             w_host_ok;
   logic             w_btn_req;
   logic             w_req_valid;
   logic [SEL_W-1:0] w_base;
   logic [SEL_W-1:0] w_req_code;
   logic [SEL_W-1:0] r_select;
   logic             r_ack;
   logic             r_err;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_db (
      .clk_in(clk_in), .reset_in(reset_in), .btn_in(mode_btn_in), .press_out(w_mode_press)
   );
   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_swap_db (
      .clk_in(clk_in), .reset_in(reset_in), .btn_in(swap_btn_in), .press_out(w_swap_press)
   );

   // a host strobe, good or bad, discards any button press in the same cycle
   assign w_host_ok   = host_load_in && (host_sel_in <= SEL_W'(SEL_MAX));
   assign w_btn_req   = !host_load_in && (w_mode_press || w_swap_press);
   assign w_req_valid = w_host_ok || w_btn_req;
   assign w_req_code  = w_host_ok ? host_sel_in : next_route(w_base, w_mode_press, w_swap_press);

   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         r_ack <= 1'b0;
         r_err <= 1'b0;
      end else begin
         r_ack <= w_host_ok;
         r_err <= host_load_in && !w_host_ok;
      end
   end

`ifdef ROUTE_BLANK_EN
   route_state_t     r_state;
   logic [7:0]       r_cnt;
   logic [SEL_W-1:0] r_target;
   logic [SEL_W-1:0] r_pend;
   logic             r_pend_valid;
   logic             r_blank;
   logic             r_busy;
   logic [SEL_W-1:0] w_idle_target;
   logic             w_idle_go;

   assign w_base        = r_pend_valid ? r_pend : r_select;
   assign w_idle_target = w_req_valid ? w_req_code : r_pend;
   assign w_idle_go     = (w_req_valid || r_pend_valid) && (w_idle_target != r_select);

   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         r_state      <= ST_IDLE;
         r_cnt        <= 8'd0;
         r_target     <= '0;
         r_pend       <= '0;
         r_pend_valid <= 1'b0;
         r_select     <= '0;
         r_blank      <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_pend_valid <= 1'b0;
               if (w_idle_go) begin
                  r_state  <= ST_BLANK;
                  r_cnt    <= 8'(BLANK_CYCLES - 1);
                  r_target <= w_idle_target;
                  r_blank  <= 1'b1;
                  r_busy   <= 1'b1;
               end
            end
            ST_BLANK: begin
               if (r_cnt == 8'd0) begin
                  r_state  <= ST_COMMIT;
                  r_select <= r_target;
               end else begin
                  r_cnt <= r_cnt - 8'd1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_blank <= 1'b0;
               r_busy  <= 1'b0;
            end
         endcase
         // requests during a transition park here; the newest one wins
         if (r_state != ST_IDLE && w_req_valid) begin
            r_pend       <= w_req_code;
            r_pend_valid <= 1'b1;
         end
      end
   end

   assign blank_out = r_blank;
   assign busy_out  = r_busy;
`else
   assign w_base = r_select;

   always_ff @(posedge clk_in) begin
      if (reset_in)         r_select <= '0;
      else if (w_req_valid) r_select <= w_req_code;
   end

   assign blank_out = 1'b0;
   assign busy_out  = 1'b0;
`endif

   assign select_out   = r_select;
   assign host_ack_out = r_ack;
   assign host_err_out = r_err;
endmodule

// File: tb/tb_route_sel_ctrl.sv
// tb/tb_route_sel_ctrl.sv - route_sel_ctrl bench: directed button cases plus random host loads vs a timeline model
`timescale 1ns/1ps
module tb_route_sel_ctrl;
   localparam int DEB = 8;
   localparam int BLK = 4;
`ifdef ROUTE_BLANK_EN
   localparam bit BLANK_EN = 1'b1;
`else
   localparam bit BLANK_EN = 1'b0;
`endif
   // cycles from request to the cycle in which select_out shows the new code
   localparam int LAT = BLANK_EN ? BLK + 1 : 1;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       mode_btn = 1'b0;
   logic       swap_btn = 1'b0;
   logic       host_load = 1'b0;
   logic [3:0] host_sel = 4'd0;
   logic       ack, err, blank, busy;
   logic [3:0] sel;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   route_sel_ctrl #(.DEBOUNCE_CYCLES(DEB), .BLANK_CYCLES(BLK)) dut (
      .clk_in(clk), .reset_in(rst), .mode_btn_in(mode_btn), .swap_btn_in(swap_btn),
      .host_sel_in(host_sel), .host_load_in(host_load), .host_ack_out(ack),
      .host_err_out(err), .select_out(sel), .blank_out(blank), .busy_out(busy)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // model: one transition at a time, described by its start cycle and target
   int         cyc;
   int         t0;
   bit         have_tr;
   logic [3:0] sel_old, tgt, pend;
   bit         pend_v, exp_ack, exp_err;

   function automatic logic [3:0] m_sel(input int c);
      return (have_tr && c >= t0 + LAT) ? tgt : sel_old;
   endfunction

   function automatic bit m_busy(input int c);
      return BLANK_EN && have_tr && c >= t0 + 1 && c <= t0 + LAT;
   endfunction

   task automatic model_reset();
      have_tr = 0; sel_old = 4'd0; tgt = 4'd0; pend = 4'd0;
      pend_v = 0; exp_ack = 0; exp_err = 0; cyc = 0; t0 = 0;
   endtask

   task automatic cycle(input bit ld, input logic [3:0] code, input bit mb, input bit sb);
      logic [3:0] cs, target;
      bit tv;
      check_eq("select", sel, m_sel(cyc));
      check_eq("blank", blank, m_busy(cyc));
      check_eq("busy", busy, m_busy(cyc));
      check_eq("ack", ack, exp_ack);
      check_eq("err", err, exp_err);
      host_load = ld; host_sel = code; mode_btn = mb; swap_btn = sb;
      exp_ack = ld && (code <= 4'd11);
      exp_err = ld && (code > 4'd11);
      cs = m_sel(cyc);
      if (!m_busy(cyc)) begin
         tv = 0; target = cs;
         if (exp_ack) begin target = code; tv = 1; end
         else if (pend_v) begin target = pend; tv = 1; end
         pend_v = 0;
         if (tv && target != cs) begin
            sel_old = cs; tgt = target; t0 = cyc; have_tr = 1;
         end
      end else if (exp_ack) begin
         pend = code; pend_v = 1;
      end
      @(posedge clk); #1;
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 4'd0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      rst = 1; host_load = 0; mode_btn = 0; swap_btn = 0;
      repeat (2) @(posedge clk);
      #1;
      rst = 0;
      model_reset();
   endtask

   task automatic button_run(input bit mb, input bit sb, input int hold,
                             input logic [3:0] exp_final, input string tag);
      int blank_cnt, changes, bad_change;
      logic [3:0] prev;
      blank_cnt = 0; changes = 0; bad_change = 0;
      prev = sel;
      host_load = 0;
      for (int i = 0; i < hold + 30; i++) begin
         mode_btn = (i < hold) && mb;
         swap_btn = (i < hold) && sb;
         @(posedge clk); #1;
         if (blank) blank_cnt++;
         if (sel != prev) begin
            changes++;
            if (BLANK_EN && !blank) bad_change++;
         end
         prev = sel;
      end
      check_eq({tag, "_sel"}, sel, exp_final);
      check_eq({tag, "_blank_cycles"}, blank_cnt, BLANK_EN ? BLK + 1 : 0);
      check_eq({tag, "_changes"}, changes, 1);
      check_eq({tag, "_unblanked_change"}, bad_change, 0);
      have_tr = 0; sel_old = exp_final; pend_v = 0; exp_ack = 0; exp_err = 0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      do_reset();
      check_eq("rst_select", sel, 0);
      check_eq("rst_blank", blank, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_ack", ack, 0);
      check_eq("rst_err", err, 0);

      // single debounced mode press: 0 -> 2
      button_run(1'b1, 1'b0, 20, 4'd2, "mode_press");

      // mode and swap together from 10: index wraps, swap sets bit0
      cycle(1'b1, 4'd10, 1'b0, 1'b0);
      idle(LAT + 2);
      button_run(1'b1, 1'b1, 20, 4'd1, "mode_swap");

      // illegal host code
      cycle(1'b1, 4'd13, 1'b0, 1'b0);
      idle(3);

      // host code arriving mid-transition is parked then serviced
      cycle(1'b1, 4'd2, 1'b0, 1'b0);
      cycle(1'b0, 4'd0, 1'b0, 1'b0);
      cycle(1'b1, 4'd7, 1'b0, 1'b0);
      idle(2 * LAT + 4);

      // load equal to current select is acked with no transition
      cycle(1'b1, 4'd7, 1'b0, 1'b0);
      idle(3);

      // bouncing button never settles long enough to register
      for (int i = 0; i < 50; i++) cycle(1'b0, 4'd0, ((i / 3) % 2) == 1, 1'b0);
      idle(20);

      // random host loads, including codes over the legal range
      for (int i = 0; i < 400; i++)
         cycle($urandom_range(0, 2) == 0, 4'($urandom_range(0, 15)), 1'b0, 1'b0);
      idle(2 * LAT + 4);

      // reset during the second blanking cycle aborts the transition
      cycle(1'b1, 4'd5, 1'b0, 1'b0);
      cycle(1'b0, 4'd0, 1'b0, 1'b0);
      check_eq("pre_rst_blank", blank, m_busy(cyc));
      rst = 1; host_load = 0;
      @(posedge clk); #1;
      check_eq("mid_rst_select", sel, 0);
      check_eq("mid_rst_blank", blank, 0);
      check_eq("mid_rst_busy", busy, 0);
      rst = 0;
      model_reset();
      idle(LAT + 4);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/route_sel_ctrl.md
ROUTE_SEL_CTRL -- requirements
Module: route_sel_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 250000, is the number of consecutive stable samples needed to accept a button level.
REQ-002 Parameter BLANK_CYCLES, default 16, is the length of the blanking interval in clocks, legal range 1..255.
REQ-003 clk_in  input  1  is the single system clock; all logic is on its rising edge.
REQ-004 reset_in  input  1  is the synchronous, active-high reset.
REQ-005 mode_btn_in  input  1  is the raw, asynchronous, active-high button that advances the source-pair/console route.
REQ-006 swap_btn_in  input  1  is the raw, asynchronous, active-high button that swaps player ports.
REQ-007 host_sel_in  input  4  is the route code for a direct load.
REQ-008 host_load_in  input  1  is a single-cycle strobe that requests a load of host_sel_in.
REQ-009 host_ack_out  output  1  is a one-cycle pulse meaning the host request was accepted.
REQ-010 host_err_out  output  1  is a one-cycle pulse meaning the host code was rejected (code > 11).
REQ-011 select_out  output  4  is the registered route code (0..11) that drives the controller router select.
REQ-012 blank_out  output  1  is high while routing is in transition; the router forces all outputs to 8'hFF while it is high.
REQ-013 busy_out  output  1  is high whenever the FSM is not in IDLE.

Function
REQ-014 Each button SHALL pass through a 2-flop synchronizer; the debounced level changes only after DEBOUNCE_CYCLES consecutive equal synchronized samples.
REQ-015 A debounced rising edge SHALL produce exactly one 1-cycle press pulse; release produces no pulse.
REQ-016 Route code fields SHALL be: bits[3:1] = pair/console index 0..5; bit0 = swap.
REQ-017 A mode press SHALL set target[3:1] to (base[3:1]+1) mod 6, leaving bit0 unchanged; a swap press SHALL toggle target bit0.
REQ-018 base SHALL be the pending target if one is held, else select_out.
REQ-019 Mode and swap presses in the same cycle SHALL both be applied.
REQ-020 host_load_in with code <= 11 SHALL set target to host_sel_in, and host_ack_out SHALL pulse in the next cycle.
REQ-021 host_load_in with code > 11 SHALL pulse host_err_out in the next cycle and change nothing.
REQ-022 A host load SHALL take priority over button presses in the same cycle; those presses are discarded.
REQ-023 The FSM SHALL have states IDLE, BLANK and COMMIT.
REQ-024 IDLE -> BLANK when a request or pending target differs from select_out; entry loads the counter with BLANK_CYCLES-1.
REQ-025 A request equal to select_out SHALL cause no transition; a host request is still acked.
REQ-026 BLANK SHALL decrement the counter and go to COMMIT when it reaches 0; COMMIT SHALL go to IDLE after exactly one cycle.
REQ-027 For a request sampled at cycle t from IDLE: blank_out is high from t+1 through t+BLANK_CYCLES+1 inclusive.
REQ-028 For the same request, select_out takes the new code at t+BLANK_CYCLES+1 (the COMMIT cycle), and blank_out is low at t+BLANK_CYCLES+2.
REQ-029 Requests arriving in BLANK/COMMIT SHALL update a one-deep pending register (latest wins), which is serviced in the cycle after returning to IDLE.
REQ-030 select_out SHALL never change while blank_out is low and SHALL never hold a value > 11.

Reset
REQ-031 On reset: select_out=0, blank_out=0, busy_out=0, host_ack_out=0, host_err_out=0, state=IDLE, pending cleared, debounce counters and debounced levels 0.
REQ-032 Reset asserted mid-BLANK or mid-COMMIT SHALL abort the transition; select_out returns to 0 with no commit of the target.

Configuration
REQ-033 Macro ROUTE_BLANK_EN SHALL control the blanking feature.
REQ-034 With ROUTE_BLANK_EN defined, behaviour is as in REQ-023..REQ-029.
REQ-035 Without ROUTE_BLANK_EN, select_out SHALL update at t+1, blank_out and busy_out are tied 0, and there is no FSM or pending register.

Structure
REQ-036 Package route_pkg SHALL hold the FSM state enum, SEL_MAX=11, PAIR_COUNT=6 and the route-code width of 4.
REQ-037 One sub-module, btn_debounce (synchronizer, debounce counter, press pulse), SHALL be instantiated once per button.

Verification (DEBOUNCE_CYCLES=8, BLANK_CYCLES=4)
REQ-038 Reset, then hold mode_btn_in high for 20 cycles -> one press; select_out goes 0 -> 2, blank_out is high for exactly 5 cycles.
REQ-039 Press mode and swap in the same cycle from select 10 -> select_out=1 (index wraps 5->0, bit0 set).
REQ-040 Host load of 13 -> host_err_out pulses once, select_out unchanged, busy_out stays 0.
REQ-041 Host load of 7 during BLANK toward 2 -> commits 2, returns to IDLE, then blanks again and commits 7; host_ack_out pulses once.
REQ-042 Raw mode_btn_in toggling every 3 cycles for 50 cycles -> no press pulse, select_out unchanged.
REQ-043 Assert reset_in in the 2nd BLANK cycle -> next cycle select_out=0, blank_out=0, busy_out=0.
